// File: rtl/adder_slice_scheduler.sv
// Round-robin scheduler that shares one SLICE-bit adder partition among NREQ requesters,
// rippling carry slice by slice. Optional ASCHED_ERR_MON_EN adds an exact-sum mismatch monitor.
module adder_slice_scheduler #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    parameter int NREQ  = 3,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic [SLICE-1:0]      sl_a,
    output logic [SLICE-1:0]      sl_b,
    output logic                  sl_cin,
    input  logic [SLICE-1:0]      sl_sum,
    input  logic                  sl_cout,
    output logic [15:0]           err_cnt,
    output logic                  err_flag
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IXW = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [IDW-1:0]   id;
    } op_t;

    state_t         state, state_nx;
    op_t            op_q;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    int             scan;
    logic [IXW-1:0] idx;
    logic           carry;
    logic [WIDTH:0] sum_q;
    logic           last_slice;
    logic           handshake;

    // Search starts at rr_ptr and wraps, so the requester after the last winner has priority.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan      = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NREQ) scan = scan - NREQ;
            if (!grant_vld && req_valid[scan]) begin
                grant     = IDW'(scan);
                grant_vld = 1'b1;
            end
        end
    end

    assign last_slice = (idx == IXW'(NSL - 1));
    assign handshake  = (state == DONE) && rsp_ready;

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        sl_a      = '0;
        sl_b      = '0;
        sl_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    state_nx         = RUN;
                end
            end
            RUN: begin
                sl_a   = op_q.a[idx*SLICE +: SLICE];
                sl_b   = op_q.b[idx*SLICE +: SLICE];
                sl_cin = carry;
                if (last_slice) state_nx = DONE;
            end
            DONE: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            op_q   <= '0;
            sum_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_q.a <= req_a[grant*WIDTH +: WIDTH];
                        op_q.b <= req_b[grant*WIDTH +: WIDTH];
                        op_q.id <= grant;
                        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        idx    <= '0;
                        carry  <= 1'b0;
                    end
                end
                RUN: begin
                    // Partition output is taken as-is; no correction of approximate slices.
                    sum_q[idx*SLICE +: SLICE] <= sl_sum;
                    carry <= sl_cout;
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        sum_q[WIDTH] <= sl_cout;
                        idx          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_id    = op_q.id;

`ifdef ASCHED_ERR_MON_EN
    logic [WIDTH:0] exact;

    assign exact = {1'b0, op_q.a} + {1'b0, op_q.b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (handshake && (sum_q != exact)) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            err_flag <= 1'b1;
        end
    end
`else
    assign err_cnt  = '0;
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_adder_slice_scheduler.sv
// Bench for adder_slice_scheduler: exact (optionally bit-flipping) 4-bit slice model,
// randomized operands, arbitration and result checked against arithmetic reference.
module tb_adder_slice_scheduler;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int N   = 3;
    localparam int NSL = W / S;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic             rsp_valid, rsp_ready;
    logic [W:0]       rsp_sum;
    logic [1:0]       rsp_id;
    logic [S-1:0]     sl_a, sl_b, sl_sum;
    logic             sl_cin, sl_cout;
    logic [15:0]      err_cnt;
    logic             err_flag;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];
    logic             flip;
    logic [S:0]       slice_full;

    int vec = 0;
    int errs = 0;
    int model_ptr = 0;
    int model_err = 0;

    adder_slice_scheduler #(.WIDTH(W), .SLICE(S), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin),
        .sl_sum(sl_sum), .sl_cout(sl_cout),
        .err_cnt(err_cnt), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    // Adder partition model: exact slice add, optional LSB corruption.
    always_comb begin
        slice_full = {1'b0, sl_a} + {1'b0, sl_b} + {4'd0, sl_cin};
        sl_sum     = slice_full[S-1:0] ^ {3'b000, flip};
        sl_cout    = slice_full[S];
    end

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    // One complete transaction; called #1 after a rising edge with the DUT in IDLE.
    task automatic one_op(input logic [N-1:0] vld, input int hold);
        int           g;
        int           p;
        int unsigned  m, ec;
        logic [N-1:0] exp_rdy;
        logic [W:0]   exp_sum;
        g = -1;
        for (int k = 0; k < N; k++) begin
            p = (model_ptr + k) % N;
            if (g < 0 && vld[p]) g = p;
        end
        req_valid = vld;
        #1;
        exp_rdy    = '0;
        exp_rdy[g] = 1'b1;
        vec++;
        if (req_ready !== exp_rdy) begin
            errs++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        exp_sum = ({1'b0, op_a[g]} + {1'b0, op_b[g]}) ^ (flip ? 17'h01111 : 17'h00000);
        @(posedge clk); #1;
        model_ptr = (g + 1) % N;
        for (int k = 0; k < NSL; k++) begin
            m  = (32'd1 << (S * k)) - 32'd1;
            ec = ((32'(op_a[g]) & m) + (32'(op_b[g]) & m)) >> (S * k);
            vec++;
            if (sl_a !== op_a[g][k*S +: S] || sl_b !== op_b[g][k*S +: S] || sl_cin !== ec[0]
                || req_ready !== '0 || rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL slice%0d: a=%h b=%h cin=%b rdy=%b vld=%b expected a=%h b=%h cin=%b rdy=0 vld=0",
                         k, sl_a, sl_b, sl_cin, req_ready, rsp_valid, op_a[g][k*S +: S], op_b[g][k*S +: S], ec[0]);
            end
            @(posedge clk); #1;
        end
        vec++;
        if (rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL latency: rsp_valid=%b expected 1", rsp_valid);
        end
        for (int h = 0; h < hold; h++) begin
            vec++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== 2'(g) || req_ready !== '0) begin
                errs++;
                $display("FAIL hold%0d: vld=%b sum=%h id=%0d rdy=%b expected 1 %h %0d 0",
                         h, rsp_valid, rsp_sum, rsp_id, req_ready, exp_sum, g);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        vec++;
        if (rsp_sum !== exp_sum || rsp_id !== 2'(g)) begin
            errs++;
            $display("FAIL result: sum=%h id=%0d expected %h %0d", rsp_sum, rsp_id, exp_sum, g);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (flip) model_err++;
        vec++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_hs: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        vec++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0
            || sl_a !== '0 || sl_b !== '0 || sl_cin !== 1'b0 || err_cnt !== '0 || err_flag !== 1'b0) begin
            errs++;
            $display("FAIL reset: rdy=%b vld=%b sum=%h id=%0d sla=%h slb=%h cin=%b ecnt=%0d eflag=%b expected all 0",
                     req_ready, rsp_valid, rsp_sum, rsp_id, sl_a, sl_b, sl_cin, err_cnt, err_flag);
        end
    endtask

    task automatic test_directed();
        op_a[0] = 16'h1234; op_b[0] = 16'h0FFF;
        one_op(3'b001, 0);
        op_a[0] = 16'hFFFF; op_b[0] = 16'h0001;
        one_op(3'b001, 0);
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; #1; rst = 1'b0; model_ptr = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
        end
        for (int r = 0; r < 3; r++) one_op(3'b101, 0);
    endtask

    task automatic test_backpressure();
        op_a[1] = 16'hA5A5; op_b[1] = 16'h5A5B;
        one_op(3'b111, 3);
    endtask

    task automatic test_reset_midrun();
        req_valid = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        #1;
        vec++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0
            || sl_a !== '0 || sl_b !== '0 || sl_cin !== 1'b0) begin
            errs++;
            $display("FAIL midrun_reset: rdy=%b vld=%b sum=%h id=%0d sla=%h slb=%h cin=%b expected all 0",
                     req_ready, rsp_valid, rsp_sum, rsp_id, sl_a, sl_b, sl_cin);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        model_err = 0;
        for (int c = 0; c < 6; c++) begin
            vec++;
            if (rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL aborted_rsp: rsp_valid=%b expected 0 (cycle %0d)", rsp_valid, c);
            end
            @(posedge clk); #1;
        end
        one_op(3'b111, 0);
    endtask

    task automatic test_err_monitor();
        logic [15:0] exp_cnt;
        logic        exp_flag;
        flip = 1'b1;
        for (int r = 0; r < 3; r++) begin
            op_a[r] = 16'($urandom); op_b[r] = 16'($urandom);
            one_op(3'b111, 0);
        end
        flip = 1'b0;
`ifdef ASCHED_ERR_MON_EN
        exp_cnt = 16'(model_err); exp_flag = 1'b1;
`else
        exp_cnt = 16'd0; exp_flag = 1'b0;
`endif
        vec++;
        if (err_cnt !== exp_cnt || err_flag !== exp_flag) begin
            errs++;
            $display("FAIL err_mon: cnt=%0d flag=%b expected %0d %b", err_cnt, err_flag, exp_cnt, exp_flag);
        end
        for (int r = 0; r < 3; r++) one_op(3'b111, 0);
        vec++;
        if (err_cnt !== exp_cnt || err_flag !== exp_flag) begin
            errs++;
            $display("FAIL err_exact: cnt=%0d flag=%b expected %0d %b", err_cnt, err_flag, exp_cnt, exp_flag);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
            end
            one_op(3'($urandom_range(1, 7)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        flip      = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0;
        end
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midrun();
        test_err_monitor();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
